cluster_clock_gate_mgr: RTL and testbench



---
 rtl/cluster_clock_gate_pkg.sv | 21 ++
 rtl/cluster_clock_gate_chan.sv | 90 +++++++++
 rtl/cluster_clock_gate_icg.sv | 20 ++
 rtl/cluster_clock_gate_mgr.sv | 43 ++++
 tb/tb_cluster_clock_gate_mgr.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/cluster_clock_gate_pkg.sv
// Shared types and default parameters for the cluster clock-gating manager.
// Every channel and the top level import this package.
package cluster_clock_gate_pkg;

   typedef enum logic [1:0] {
      CH_OFF  = 2'd0,
      CH_WAKE = 2'd1,
      CH_ON   = 2'd2,
      CH_IDLE = 2'd3
   } chan_state_e;

   localparam int DEF_NUM_CH      = 4;
   localparam int DEF_IDLE_W      = 8;
   localparam int DEF_WAKE_CYCLES = 2;

   // The wake counter holds WAKE_CYCLES-1, and its width never drops below one bit.
   function automatic int wake_cnt_width(input int cycles);
      return (cycles > 2) ? $clog2(cycles) : 1;
   endfunction

endpackage

// File: rtl/cluster_clock_gate_chan.sv
// One gated-clock channel. It contains the OFF/WAKE/ON/IDLE FSM with the wake settle
// counter and the idle auto-gate counter, and registers its ack and clk_en outputs.
module cluster_clock_gate_chan
   import cluster_clock_gate_pkg::*;
#(
   parameter int IDLE_W      = DEF_IDLE_W,
   parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [IDLE_W-1:0] idle_thresh,
   input  logic              req,
   input  logic              busy,
   output logic              ack,
   output logic              clk_en
);

   localparam int                WAKE_W    = wake_cnt_width(WAKE_CYCLES);
   localparam logic [WAKE_W-1:0] WAKE_LOAD = WAKE_W'(WAKE_CYCLES - 1);

   chan_state_e       state_reg, state_next;
   logic [WAKE_W-1:0] wake_cnt_reg, wake_cnt_next;
   logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
   logic              ack_reg, ack_next;
   logic              clk_en_reg, clk_en_next;

   always_ff @(posedge clk) begin
      if (srst) begin
         state_reg    <= CH_OFF;
         wake_cnt_reg <= '0;
         idle_cnt_reg <= '0;
         ack_reg      <= 1'b0;
         clk_en_reg   <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wake_cnt_reg <= wake_cnt_next;
         idle_cnt_reg <= idle_cnt_next;
         ack_reg      <= ack_next;
         clk_en_reg   <= clk_en_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wake_cnt_next = wake_cnt_reg;
      idle_cnt_next = idle_cnt_reg;
      unique case (state_reg)
         CH_OFF: begin
            if (req) begin
               state_next    = CH_WAKE;
               wake_cnt_next = WAKE_LOAD;
            end
         end
         CH_WAKE: begin
            if (wake_cnt_reg == '0) begin
               state_next = CH_ON;
            end else begin
               wake_cnt_next = wake_cnt_reg - WAKE_W'(1);
            end
         end
         CH_ON: begin
            if (!req && !busy) begin
               state_next    = CH_IDLE;
               idle_cnt_next = idle_thresh;
            end
         end
         CH_IDLE: begin
            // Activity takes priority over the counter reaching zero.
            if (req || busy) begin
               state_next = CH_ON;
            end else if (idle_cnt_reg == '0) begin
               state_next = CH_OFF;
            end else begin
               idle_cnt_next = idle_cnt_reg - IDLE_W'(1);
            end
         end
         default: state_next = CH_OFF;
      endcase
   end

   // The outputs are decoded from the next state so that they leave a flop in step with the state.
   always_comb begin
      clk_en_next = (state_next != CH_OFF);
      ack_next    = (state_next == CH_ON) || (state_next == CH_IDLE);
   end

   assign ack    = ack_reg;
   assign clk_en = clk_en_reg;

endmodule

// File: rtl/cluster_clock_gate_icg.sv
// Latch-based clock-gating cell. The enable is captured only while clk is low,
// so the gated clock never shows a glitch or a shortened high phase.
module cluster_clock_gate_icg (
   input  logic clk,
   input  logic en,
   input  logic test_en,
   output logic gclk
);

   logic en_lat;

   always_latch begin
      if (!clk) begin
         en_lat = en | test_en;
      end
   end

   assign gclk = clk & en_lat;

endmodule

// File: rtl/cluster_clock_gate_mgr.sv
// Multi-channel clock-gating manager. Each channel has its own FSM and clock-gating cell,
// and all channels share the cluster root clock, the idle threshold and the DFT enable.
module cluster_clock_gate_mgr
   import cluster_clock_gate_pkg::*;
#(
   parameter int NUM_CH      = DEF_NUM_CH,
   parameter int IDLE_W      = DEF_IDLE_W,
   parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              test_en_i,
   input  logic [IDLE_W-1:0] idle_thresh_i,
   input  logic [NUM_CH-1:0] req_i,
   input  logic [NUM_CH-1:0] busy_i,
   output logic [NUM_CH-1:0] ack_o,
   output logic [NUM_CH-1:0] clk_en_o,
   output logic [NUM_CH-1:0] clk_o
);

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      cluster_clock_gate_chan #(
         .IDLE_W      (IDLE_W),
         .WAKE_CYCLES (WAKE_CYCLES)
      ) u_chan (
         .clk         (clk_i),
         .srst        (rst_i),
         .idle_thresh (idle_thresh_i),
         .req         (req_i[gi]),
         .busy        (busy_i[gi]),
         .ack         (ack_o[gi]),
         .clk_en      (clk_en_o[gi])
      );

      cluster_clock_gate_icg u_icg (
         .clk     (clk_i),
         .en      (clk_en_o[gi]),
         .test_en (test_en_i),
         .gclk    (clk_o[gi])
      );
   end

endmodule

// File: tb/tb_cluster_clock_gate_mgr.sv
// Self-checking bench for cluster_clock_gate_mgr. It applies a vector table and then corner-case sequences.
// Expected ack/clk_en values go through a scoreboard queue, and gated-clock edges are counted per channel.
module tb_cluster_clock_gate_mgr;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       test_en_i;
   logic [7:0] idle_thresh_i;
   logic [3:0] req_i;
   logic [3:0] busy_i;
   logic [3:0] ack_o;
   logic [3:0] clk_en_o;
   logic [3:0] clk_o;

   cluster_clock_gate_mgr #(
      .NUM_CH      (4),
      .IDLE_W      (8),
      .WAKE_CYCLES (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .test_en_i     (test_en_i),
      .idle_thresh_i (idle_thresh_i),
      .req_i         (req_i),
      .busy_i        (busy_i),
      .ack_o         (ack_o),
      .clk_en_o      (clk_en_o),
      .clk_o         (clk_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] busy;
      logic [7:0] thr;
      logic       ten;
      logic [3:0] ack;
      logic [3:0] en;
   } vec_t;

   typedef struct {
      logic [3:0] ack;
      logic [3:0] en;
      string      name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_txn    = 0;

   // Count the rising edges seen on each gated clock.
   int         edge_cnt[4] = '{default: 0};
   logic [3:0] clk_o_prev  = 4'h0;
   always @(clk_o) begin
      for (int i = 0; i < 4; i++) begin
         if (clk_o[i] && !clk_o_prev[i]) edge_cnt[i]++;
      end
      clk_o_prev = clk_o;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Inputs change on the falling edge, the DUT samples them on the next rising edge,
   // and the scoreboard entry is checked on the falling edge that follows.
   task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] bz,
                        input logic [7:0] th, input logic te,
                        input logic [3:0] eack, input logic [3:0] een, input string nm);
      exp_t e;
      rst_i         = r;
      req_i         = rq;
      busy_i        = bz;
      idle_thresh_i = th;
      test_en_i     = te;
      sb_q.push_back('{eack, een, nm});
      @(posedge clk_i);
      @(negedge clk_i);
      n_txn++;
      if (sb_q.size() == 0) begin
         check({nm, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         $display("txn %0d %s: rst=%b req=%h busy=%h thr=%0d ten=%b -> ack=%h en=%h (exp ack=%h en=%h)",
                  n_txn, e.name, r, rq, bz, th, te, ack_o, clk_en_o, e.ack, e.en);
         check({e.name, "_ack"}, 32'(ack_o), 32'(e.ack));
         check({e.name, "_clk_en"}, 32'(clk_en_o), 32'(e.en));
      end
   endtask

   vec_t tbl[16];
   int   snap[4];
   int   snap0;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1; test_en_i = 1'b0; idle_thresh_i = 8'd5; req_i = 4'h0; busy_i = 4'h0;

      //            rst   req    busy   thr    ten   ack    en
      tbl[0]  = '{1'b1, 4'hF, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0};
      tbl[1]  = '{1'b1, 4'hF, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0};
      tbl[2]  = '{1'b1, 4'hF, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0};
      tbl[3]  = '{1'b0, 4'h0, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0};
      tbl[4]  = '{1'b0, 4'h1, 4'h0, 8'd5, 1'b0, 4'h0, 4'h1};  // ch0 wake starts
      tbl[5]  = '{1'b0, 4'h1, 4'h0, 8'd5, 1'b0, 4'h0, 4'h1};
      tbl[6]  = '{1'b0, 4'h1, 4'h0, 8'd5, 1'b0, 4'h1, 4'h1};  // ch0 acked
      tbl[7]  = '{1'b0, 4'h1, 4'h2, 8'd5, 1'b0, 4'h1, 4'h1};  // busy alone cannot wake ch1
      tbl[8]  = '{1'b0, 4'h5, 4'h0, 8'd5, 1'b0, 4'h1, 4'h5};  // ch2 wake starts
      tbl[9]  = '{1'b0, 4'h1, 4'h0, 8'd5, 1'b0, 4'h1, 4'h5};  // ch2 req dropped mid-wake
      tbl[10] = '{1'b0, 4'h1, 4'h0, 8'd5, 1'b0, 4'h5, 4'h5};  // ch2 completes to ON
      tbl[11] = '{1'b0, 4'h1, 4'h0, 8'd1, 1'b0, 4'h5, 4'h5};  // ch2 idle, thresh 1
      tbl[12] = '{1'b0, 4'h1, 4'h0, 8'd1, 1'b0, 4'h5, 4'h5};
      tbl[13] = '{1'b0, 4'h1, 4'h0, 8'd5, 1'b0, 4'h1, 4'h1};  // ch2 off
      tbl[14] = '{1'b0, 4'h0, 4'h0, 8'd0, 1'b0, 4'h1, 4'h1};  // ch0 idle, thresh 0
      tbl[15] = '{1'b0, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0};  // ch0 off

      @(negedge clk_i);
      snap = edge_cnt;
      for (int i = 0; i < 16; i++) begin
         if (i == 4) snap0 = edge_cnt[0];
         drive(tbl[i].rst, tbl[i].req, tbl[i].busy, tbl[i].thr, tbl[i].ten,
               tbl[i].ack, tbl[i].en, $sformatf("tbl%0d", i));
         if (i == 3) begin
            for (int c = 0; c < 4; c++)
               check($sformatf("reset_flat_clk_o%0d", c), 32'(edge_cnt[c] - snap[c]), 32'd0);
         end
         if (i == 4) check("wake_no_edge_on_req_edge", 32'(edge_cnt[0] - snap0), 32'd0);
         if (i == 5) check("wake_first_gated_edge", 32'(edge_cnt[0] - snap0), 32'd1);
      end

      // Auto-gate ch1 with thresh 5: the channel goes OFF six edges after the quiet edge.
      repeat (2) drive(1'b0, 4'h2, 4'h0, 8'd5, 1'b0, 4'h0, 4'h2, "ag_wake");
      drive(1'b0, 4'h2, 4'h0, 8'd5, 1'b0, 4'h2, 4'h2, "ag_on");
      drive(1'b0, 4'h0, 4'h0, 8'd5, 1'b0, 4'h2, 4'h2, "ag_quiet");
      snap0 = edge_cnt[1];
      for (int k = 1; k <= 5; k++)
         drive(1'b0, 4'h0, 4'h0, 8'd9, 1'b0, 4'h2, 4'h2, $sformatf("ag_idle%0d", k));
      drive(1'b0, 4'h0, 4'h0, 8'd9, 1'b0, 4'h0, 4'h0, "ag_off");
      repeat (2) drive(1'b0, 4'h0, 4'h0, 8'd9, 1'b0, 4'h0, 4'h0, "ag_stay_off");
      check("ag_edges_after_quiet", 32'(edge_cnt[1] - snap0), 32'd6);

      // Re-arm ch2 with a one-cycle busy pulse when its counter is at 2, then check the reload on re-entry.
      repeat (2) drive(1'b0, 4'h4, 4'h0, 8'd5, 1'b0, 4'h0, 4'h4, "ra_wake");
      drive(1'b0, 4'h4, 4'h0, 8'd5, 1'b0, 4'h4, 4'h4, "ra_on");
      for (int k = 0; k < 4; k++)
         drive(1'b0, 4'h0, 4'h0, 8'd5, 1'b0, 4'h4, 4'h4, $sformatf("ra_idle%0d", k));
      drive(1'b0, 4'h0, 4'h4, 8'd5, 1'b0, 4'h4, 4'h4, "ra_busy_pulse");
      for (int k = 0; k < 6; k++)
         drive(1'b0, 4'h0, 4'h0, 8'd5, 1'b0, 4'h4, 4'h4, $sformatf("ra_reidle%0d", k));
      drive(1'b0, 4'h0, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0, "ra_off");

      // On ch0, req arriving on the same edge the idle counter reaches zero keeps the channel ON.
      repeat (2) drive(1'b0, 4'h1, 4'h0, 8'd2, 1'b0, 4'h0, 4'h1, "cz_wake");
      drive(1'b0, 4'h1, 4'h0, 8'd2, 1'b0, 4'h1, 4'h1, "cz_on");
      for (int k = 0; k < 3; k++)
         drive(1'b0, 4'h0, 4'h0, 8'd2, 1'b0, 4'h1, 4'h1, $sformatf("cz_idle%0d", k));
      drive(1'b0, 4'h1, 4'h0, 8'd2, 1'b0, 4'h1, 4'h1, "cz_req_wins");
      drive(1'b0, 4'h1, 4'h0, 8'd2, 1'b0, 4'h1, 4'h1, "cz_hold_on");
      drive(1'b0, 4'h0, 4'h0, 8'd0, 1'b0, 4'h1, 4'h1, "cz_idle_t0");
      drive(1'b0, 4'h0, 4'h0, 8'd0, 1'b0, 4'h0, 4'h0, "cz_off");

      // Reset in the middle of a wake returns ch3 to OFF.
      drive(1'b0, 4'h8, 4'h0, 8'd5, 1'b0, 4'h0, 4'h8, "rw_wake");
      drive(1'b1, 4'h8, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0, "rw_reset");
      drive(1'b0, 4'h0, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0, "rw_after");

      // With test enable set, every gated clock runs while the FSMs stay OFF.
      snap = edge_cnt;
      repeat (4) drive(1'b0, 4'h0, 4'h0, 8'd5, 1'b1, 4'h0, 4'h0, "dft_on");
      for (int c = 0; c < 4; c++)
         check($sformatf("dft_edges_ch%0d", c), 32'(edge_cnt[c] - snap[c]), 32'd4);
      repeat (2) drive(1'b0, 4'h0, 4'h0, 8'd5, 1'b0, 4'h0, 4'h0, "dft_off");
      for (int c = 0; c < 4; c++)
         check($sformatf("dft_stopped_ch%0d", c), 32'(edge_cnt[c] - snap[c]), 32'd4);

      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
